// File: rtl/yag_shot_sequencer.sv
// yag_shot_sequencer
// Schedules Nd:YAG shots by issuing single-cycle triggers to the flash/Q-switch
// controller at a programmable repetition period. A burst is either a counted
// number of shots or continuous until aborted. A due shot is deferred, not
// dropped, while the interlock inhibit is high. The flash-to-Q delay is latched
// at start and held stable for the whole burst. A start whose period would
// retrigger the controller mid-sequence is refused and flagged in err_o.
//
// Ports
//   clk_i       system clock
//   rst_n_i     asynchronous active-low reset
//   start_i     start a burst (sampled only while idle)
//   abort_i     stop the burst, no further triggers
//   inhibit_i   interlock, defers a due shot while high
//   period_i    shot-to-shot period in clk cycles
//   n_shots_i   shots per burst, 0 = continuous
//   delay_i     flash-to-Q delay forwarded to the controller
//   trig_o      1-cycle trigger pulse
//   delay_o     latched delay, stable while busy_o=1
//   busy_o      burst in progress
//   done_o      1-cycle pulse when a counted burst completes
//   shot_cnt_o  shots fired in current/last burst
//   err_o       sticky, last start was rejected
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start_i; validates period and interlock
// FIRE   | trig_o high for exactly one cycle; reloads the period timer
// WAIT   | period timer counting down; shot deferred while inhibited
// DONE   | counted burst finished; done_o high for one cycle
module yag_shot_sequencer #(
  parameter int unsigned MIN_PERIOD = 12000,
  parameter int unsigned Q_HOLDOFF  = 6000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        inhibit_i,
  input  logic [31:0] period_i,
  input  logic [15:0] n_shots_i,
  input  logic [31:0] delay_i,
  output logic        trig_o,
  output logic [31:0] delay_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] shot_cnt_o,
  output logic        err_o
);

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] timer, timer_nxt;
  logic [31:0] period_q, period_nxt;
  logic [15:0] n_q, n_nxt;
  logic [31:0] delay_nxt;
  logic [15:0] cnt_nxt;
  logic        err_nxt, trig_nxt, busy_nxt, done_nxt;

  logic [32:0] min_gap;
  logic        period_ok, start_ok, timer_zero, burst_end;

  // Sum kept in 33 bits so a huge delay cannot wrap and make a short period look legal.
  assign min_gap    = {1'b0, delay_i} + 33'(Q_HOLDOFF) + 33'd2;
  assign period_ok  = (period_i >= 32'(MIN_PERIOD)) && ({1'b0, period_i} > min_gap);
  assign start_ok   = start_i && period_ok && !inhibit_i;
  assign timer_zero = (timer == 32'd0);
  assign burst_end  = (n_q != 16'd0) && (shot_cnt_o == n_q);

  // State and all outputs registered together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      timer      <= '0;
      period_q   <= '0;
      n_q        <= '0;
      delay_o    <= '0;
      shot_cnt_o <= '0;
      err_o      <= 1'b0;
      trig_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      period_q   <= period_nxt;
      n_q        <= n_nxt;
      delay_o    <= delay_nxt;
      shot_cnt_o <= cnt_nxt;
      err_o      <= err_nxt;
      trig_o     <= trig_nxt;
      busy_o     <= busy_nxt;
      done_o     <= done_nxt;
    end
  end

  // Next state; abort overrides everything once a burst is running.
  always_comb begin
    state_nxt = state;
    if (state != S_IDLE && abort_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start_ok) state_nxt = S_FIRE;
        S_FIRE: state_nxt = S_WAIT;
        S_WAIT: begin
          if (timer_zero) begin
            if (burst_end)       state_nxt = S_DONE;
            else if (!inhibit_i) state_nxt = S_FIRE;
          end
        end
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values. Flags are decoded from the next state so
  // they line up with the state register without a combinational output path.
  always_comb begin
    timer_nxt  = timer;
    period_nxt = period_q;
    n_nxt      = n_q;
    delay_nxt  = delay_o;
    cnt_nxt    = shot_cnt_o;
    err_nxt    = err_o;
    trig_nxt   = (state_nxt == S_FIRE);
    busy_nxt   = (state_nxt != S_IDLE);
    done_nxt   = (state_nxt == S_DONE);

    case (state)
      S_IDLE: begin
        if (start_i) begin
          if (start_ok) begin
            period_nxt = period_i;
            n_nxt      = n_shots_i;
            delay_nxt  = delay_i;
            cnt_nxt    = '0;
            err_nxt    = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_FIRE: begin
        // The pulse is already out this cycle, so it is counted even on abort.
        cnt_nxt   = shot_cnt_o + 16'd1;
        // FIRE cycle plus (period-1) WAIT cycles gives exactly period between pulses.
        timer_nxt = period_q - 32'd2;
      end
      S_WAIT: begin
        if (!timer_zero) timer_nxt = timer - 32'd1;
      end
      default: ;
    endcase

    if (state_nxt == S_IDLE) timer_nxt = '0;
  end

endmodule

// File: tb/tb_yag_shot_sequencer.sv
module tb_yag_shot_sequencer;
  // Scaled-down timing constants keep the run short; ratios match the real part.
  localparam int MIN_P = 120;
  localparam int QH    = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, inhibit = 1'b0;
  logic [31:0] period = '0, delay = '0;
  logic [15:0] n_shots = '0;
  logic        trig, busy, done, err;
  logic [31:0] delay_q;
  logic [15:0] cnt;

  yag_shot_sequencer #(.MIN_PERIOD(MIN_P), .Q_HOLDOFF(QH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
    .inhibit_i(inhibit), .period_i(period), .n_shots_i(n_shots),
    .delay_i(delay), .trig_o(trig), .delay_o(delay_q), .busy_o(busy),
    .done_o(done), .shot_cnt_o(cnt), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: tracks the absolute edge at which the next shot is due
  // instead of a countdown timer.
  logic        m_trig, m_busy, m_done, m_err;
  logic [15:0] m_cnt, m_n;
  logic [31:0] m_delay, m_period;
  longint      m_due, m_edge;
  bit          prev_trig, prev_done;

  function automatic bit valid(input logic [31:0] p, input logic [31:0] d);
    longint lp, ld;
    lp = longint'({32'b0, p});
    ld = longint'({32'b0, d});
    return (lp >= MIN_P) && (lp > ld + QH + 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_trig = 0; m_busy = 0; m_done = 0; m_err = 0;
      m_cnt = 0; m_n = 0; m_delay = 0; m_period = 0; m_due = 0; m_edge = 0;
    end else begin
      m_edge++;
      prev_trig = m_trig;
      prev_done = m_done;
      m_trig = 0;
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          if (valid(period, delay) && !inhibit) begin
            m_busy = 1; m_trig = 1; m_cnt = 0; m_err = 0;
            m_period = period; m_n = n_shots; m_delay = delay;
            m_due = m_edge + longint'(m_period);
          end else m_err = 1;
        end
      end else if (abort) begin
        m_busy = 0;
        if (prev_trig) m_cnt++;
      end else if (prev_done) begin
        m_busy = 0;
      end else if (prev_trig) begin
        m_cnt++;
      end else if (m_edge >= m_due) begin
        if (m_n != 0 && m_cnt == m_n) m_done = 1;
        else if (!inhibit) begin
          m_trig = 1;
          m_due = m_edge + longint'(m_period);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("trig", 64'(trig), 64'(m_trig));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("err", 64'(err), 64'(m_err));
    chk("shot_cnt", 64'(cnt), 64'(m_cnt));
    chk("delay_o", 64'(delay_q), 64'(m_delay));
  end

  task automatic wait_trig(input string name, output int t, input int budget);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (trig) begin t = cyc; break; end
    end
    n_checks++;
    if (t >= 0) n_pass++;
    else $display("FAIL %s: no trig_o within %0d cycles, required one", name, budget);
  endtask

  task automatic wait_done(input string name, output int t, input int budget);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin t = cyc; break; end
    end
    n_checks++;
    if (t >= 0) n_pass++;
    else $display("FAIL %s: no done_o within %0d cycles, required one", name, budget);
  endtask

  // Inputs applied at a negedge, start held for one cycle.
  task automatic try_start(input logic [31:0] p, input logic [15:0] n, input logic [31:0] d,
                           input logic inh);
    period = p; n_shots = n; delay = d; inhibit = inh; start = 1'b1;
    @(negedge clk);
    start = 1'b0; inhibit = 1'b0;
  endtask

  task automatic run_t1(input string tag);
    int t1, t2, t3, td;
    try_start(120, 3, 36, 1'b0);
    chk({tag, "_first_trig"}, 64'(trig), 64'd1);
    t1 = cyc;
    wait_trig({tag, "_trig2"}, t2, 300);
    chk({tag, "_gap12"}, 64'(t2 - t1), 64'd120);
    wait_trig({tag, "_trig3"}, t3, 300);
    chk({tag, "_gap23"}, 64'(t3 - t2), 64'd120);
    wait_done({tag, "_done"}, td, 300);
    chk({tag, "_done_time"}, 64'(td - t3), 64'd120);
    chk({tag, "_cnt"}, 64'(cnt), 64'd3);
    chk({tag, "_model_cnt"}, 64'(m_cnt), 64'd3);
    chk({tag, "_delay"}, 64'(delay_q), 64'd36);
    @(negedge clk);
    chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
    chk({tag, "_done_fall"}, 64'(done), 64'd0);
  endtask

  initial begin
    int t1, t2, t3, td, extra;
    int inh_left;

    repeat (3) @(negedge clk);
    chk("rst_trig", 64'(trig), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: basic counted burst
    run_t1("t1");

    // T2: rejected starts, boundaries, then a valid start clears err
    try_start(90, 3, 36, 1'b0);
    chk("t2_short_err", 64'(err), 64'd1);
    chk("t2_short_busy", 64'(busy), 64'd0);
    try_start(120, 3, 60, 1'b0);
    chk("t2_holdoff_err", 64'(err), 64'd1);
    chk("t2_holdoff_trig", 64'(trig), 64'd0);
    try_start(119, 3, 0, 1'b0);
    chk("t2_min_minus1_busy", 64'(busy), 64'd0);
    try_start(120, 3, 58, 1'b0);
    chk("t2_gap_equal_busy", 64'(busy), 64'd0);
    try_start(32'hFFFF_FFFF, 3, 32'hFFFF_FFFF, 1'b0);
    chk("t2_overflow_busy", 64'(busy), 64'd0);
    try_start(120, 3, 36, 1'b1);
    chk("t2_inhibited_busy", 64'(busy), 64'd0);
    chk("t2_inhibited_err", 64'(err), 64'd1);
    try_start(120, 1, 57, 1'b0);
    chk("t2_valid_err_clear", 64'(err), 64'd0);
    chk("t2_valid_trig", 64'(trig), 64'd1);
    wait_done("t2_done", td, 300);
    @(negedge clk);

    // T3: continuous, abort after the 5th pulse
    try_start(120, 0, 10, 1'b0);
    chk("t3_first_trig", 64'(trig), 64'd1);
    for (int i = 2; i <= 5; i++) wait_trig("t3_trig", t1, 300);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_cnt", 64'(cnt), 64'd5);
    extra = 0;
    repeat (200) begin
      @(negedge clk);
      if (trig || done) extra++;
    end
    chk("t3_no_more_pulses", 64'(extra), 64'd0);

    // T4: inhibit spanning the 2nd due time
    try_start(120, 3, 20, 1'b0);
    chk("t4_first_trig", 64'(trig), 64'd1);
    t1 = cyc;
    repeat (100) @(negedge clk);
    inhibit = 1'b1;
    repeat (50) @(negedge clk);
    inhibit = 1'b0;
    wait_trig("t4_trig2", t2, 300);
    chk("t4_deferred", 64'(t2 - t1), 64'd151);
    wait_trig("t4_trig3", t3, 300);
    chk("t4_gap23", 64'(t3 - t2), 64'd120);
    wait_done("t4_done", td, 300);
    @(negedge clk);

    // T5: inputs and start disturbed mid-burst
    try_start(150, 3, 40, 1'b0);
    t1 = cyc;
    @(negedge clk);
    period = 200; delay = 99; n_shots = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_trig("t5_trig2", t2, 400);
    chk("t5_gap12", 64'(t2 - t1), 64'd150);
    chk("t5_delay", 64'(delay_q), 64'd40);
    wait_trig("t5_trig3", t3, 400);
    chk("t5_gap23", 64'(t3 - t2), 64'd150);
    wait_done("t5_done", td, 400);
    chk("t5_cnt", 64'(cnt), 64'd3);
    @(negedge clk);

    // T6: asynchronous reset mid-WAIT
    try_start(120, 3, 30, 1'b0);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_busy", 64'(busy), 64'd0);
    chk("t6_async_cnt", 64'(cnt), 64'd0);
    chk("t6_async_delay", 64'(delay_q), 64'd0);
    chk("t6_async_trig", 64'(trig), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_t1("t6_t1");

    // Randomized traffic checked cycle by cycle against the model
    inh_left = 0;
    for (int i = 0; i < 25000; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 15) == 0);
      abort   = ($urandom_range(0, 999) == 0);
      period  = $urandom_range(100, 200);
      delay   = $urandom_range(0, 90);
      n_shots = 16'($urandom_range(0, 4));
      if (inh_left > 0) inh_left--;
      else if ($urandom_range(0, 299) == 0) inh_left = $urandom_range(1, 60);
      inhibit = (inh_left > 0);
    end
    start = 1'b0; abort = 1'b0; inhibit = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
